// File: rtl/seg_pkg.sv
// Shared constants and types for the seven-segment scan controller.
package seg_pkg;
  localparam int NUM_DIGITS = 4;
  localparam logic [7:0] SEG_BLANK = 8'hFF;
  localparam logic [3:0] AN_OFF = 4'hF;

  typedef struct packed {
    logic [15:0] data;
    logic [3:0]  dp;
  } wr_req_t;

  // Active-low a..g per hex nibble; entry 15 is leftmost.
  localparam logic [15:0][6:0] HEX_TBL = {
    7'h0E, 7'h06, 7'h21, 7'h46, 7'h03, 7'h08, 7'h10, 7'h00,
    7'h78, 7'h02, 7'h12, 7'h19, 7'h30, 7'h24, 7'h79, 7'h40
  };
endpackage

// File: rtl/seg_hex_decode.sv
// Nibble to active-low seven-segment pattern, purely combinational.
module seg_hex_decode
  import seg_pkg::*;
(
  input  logic [3:0] nib,
  output logic [6:0] seg
);
  assign seg = HEX_TBL[nib];
endmodule

// File: rtl/seg_scan_ctrl.sv
// Multiplexed 4-digit display scheduler: slot timing, dead-time, PWM brightness,
// and frame-boundary commit of producer writes.
module seg_scan_ctrl
  import seg_pkg::*;
#(
  parameter int SLOT_CYC = 4096,
  parameter int DEAD_CYC = 64,
  parameter int BRIGHT_W = 4
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                wr_valid,
  output logic                wr_ready,
  input  logic [15:0]         wr_data,
  input  logic [3:0]          wr_dp,
  input  logic [3:0]          digit_en,
  input  logic                lz_blank,
  input  logic [BRIGHT_W-1:0] bright,
  output logic [3:0]          an,
  output logic [7:0]          seg,
  output logic [1:0]          digit_idx,
  output logic                frame_done
);
  localparam int SLOT_W = $clog2(SLOT_CYC);

  logic [SLOT_W-1:0] cnt;
  logic              pfull;
  wr_req_t           pend, act;

  assign frame_done = (cnt == SLOT_W'(SLOT_CYC - 1)) && (digit_idx == 2'd3);
  assign wr_ready   = ~pfull;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      cnt       <= '0;
      digit_idx <= 2'd0;
    end else begin
      cnt <= cnt + 1'b1;
      if (cnt == SLOT_W'(SLOT_CYC - 1)) digit_idx <= digit_idx + 2'd1;
    end
  end

  // Commit and accept are exclusive: accept needs pfull=0, commit needs pfull=1.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pfull <= 1'b0;
      pend  <= '0;
      act   <= '0;
    end else if (frame_done && pfull) begin
      act   <= pend;
      pfull <= 1'b0;
    end else if (wr_valid && !pfull) begin
      pend  <= '{data: wr_data, dp: wr_dp};
      pfull <= 1'b1;
    end
  end

  logic [NUM_DIGITS-1:0][6:0] dec;
  for (genvar g = 0; g < NUM_DIGITS; g++) begin : g_dec
    seg_hex_decode u_dec (.nib(act.data[4*g +: 4]), .seg(dec[g]));
  end

  // lead0[d]: nibbles d..3 of the active value are all zero.
  logic [NUM_DIGITS-1:0] lead0;
  logic blank_d, on;
  always_comb begin
    lead0 = '0;
    lead0[NUM_DIGITS-1] = (act.data[4*(NUM_DIGITS-1) +: 4] == 4'h0);
    for (int i = NUM_DIGITS - 2; i >= 0; i--)
      lead0[i] = lead0[i+1] && (act.data[4*i +: 4] == 4'h0);
    blank_d = ~digit_en[digit_idx] | (lz_blank & (digit_idx != 2'd0) & lead0[digit_idx]);
    on = (cnt >= SLOT_W'(DEAD_CYC)) && (cnt[SLOT_W-1 -: BRIGHT_W] <= bright) && !blank_d;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
    end else if (on) begin
      an  <= ~(4'b0001 << digit_idx);
      seg <= {~act.dp[digit_idx], dec[digit_idx]};
    end else begin
      an  <= AN_OFF;
      seg <= SEG_BLANK;
    end
  end
endmodule
